boot_loader: RTL and testbench
==============================

BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 128, meaning the number of 24-bit words in the target memory.
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  one-cycle pulse requesting a (re)load.
REQ-005 SHALL have port len  input  24  number of words to load; sampled on the cycle start is accepted.
REQ-006 SHALL have port byte_in  input  8  host data byte.
REQ-007 SHALL have port byte_valid  input  1  byte_in holds a valid byte.
REQ-008 SHALL have port byte_ready  output  1  loader can accept a byte this cycle.
REQ-009 SHALL have port waddr  output  24  memory write address.
REQ-010 SHALL have port wdata  output  24  memory write data.
REQ-011 SHALL have port wen  output  1  memory write enable, one cycle per word.
REQ-012 SHALL have port proc_rst  output  1  reset to the processor; high holds it in reset.
REQ-013 SHALL have port done  output  1  load complete, processor released.
REQ-014 SHALL have port err  output  1  requested length exceeds MEM_SIZE.

Function
REQ-015 SHALL implement states IDLE, B0, B1, B2, WRITE, RUN, ERR; all outputs registered.
REQ-016 SHALL, on start in IDLE, RUN or ERR: latch len; clear done and err; set proc_rst=1; zero the word counter; go to B0 if 0<len<=MEM_SIZE, to RUN if len=0, to ERR if len>MEM_SIZE.
REQ-017 SHALL ignore start while in B0, B1, B2 or WRITE.
REQ-018 SHALL drive byte_ready=1 only in B0, B1, B2; a byte is accepted on a rising edge with byte_valid=1 and byte_ready=1.
REQ-019 SHALL hold state while byte_valid=0; no timeout.
REQ-020 SHALL pack bytes little-endian: B0 byte -> word[7:0], B1 -> [15:8], B2 -> [23:16]; accepted bytes advance B0->B1->B2->WRITE.
REQ-021 SHALL, in WRITE, assert wen=1 for exactly one cycle with waddr=word counter and wdata=assembled word; wen=0 in all other states.
REQ-022 SHALL assert wen in the cycle immediately after the third byte of a word is accepted.
REQ-023 SHALL, leaving WRITE, increment the counter and go to B0 if counter+1<len, else to RUN.
REQ-024 SHALL, in RUN, drive proc_rst=0 and done=1, from the first cycle in RUN until the next start.
REQ-025 SHALL, in ERR, drive err=1, proc_rst=1, done=0, with no memory writes.
REQ-026 SHALL treat len=MEM_SIZE as legal; the last write is to address MEM_SIZE-1. Address never wraps.
REQ-027 SHALL hold waddr and wdata at their last values when wen=0.
REQ-028 SHALL keep proc_rst=1 in every state except RUN.

Reset
REQ-029 SHALL, while rst=1, immediately force: state IDLE, byte_ready=0, wen=0, waddr=0, wdata=0, counter=0, proc_rst=1, done=0, err=0.
REQ-030 SHALL abort a load in progress when rst is asserted; partially assembled bytes are discarded and no wen is issued.
REQ-031 SHALL leave IDLE only on start after rst deasserts.

Verification
REQ-032 SHALL cover: start with len=2, bytes 0x11,0x22,0x33,0x44,0x55,0x66 back-to-back -> wen at waddr 0 with wdata 0x332211, then at waddr 1 with 0x665544; done=1 and proc_rst=0 the cycle after the second WRITE.
REQ-033 SHALL cover: byte_valid toggled 1/0 every cycle, len=1, bytes 0xAA,0xBB,0xCC -> one wen, wdata 0xCCBBAA, waddr 0; byte_ready low only during WRITE.
REQ-034 SHALL cover: len=0 -> RUN the cycle after start, no wen, done=1; len=129 -> err=1, proc_rst=1, byte_ready=0, no wen.
REQ-035 SHALL cover: len=128 -> 128 writes, last at waddr 127, then done=1.
REQ-036 SHALL cover: rst asserted after the second byte of word 0 -> outputs at reset values asynchronously; a new start with len=1 writes only the three new bytes.
REQ-037 SHALL cover: start pulsed during B1 -> ignored; start pulsed in RUN -> proc_rst=1 and done=0 the next cycle, reload begins at waddr 0.

Source files
------------

// File: rtl/boot_loader_if.sv
// Host/memory-side bus of the boot loader: byte stream in, word writes and status out.
interface boot_loader_if;
    localparam int unsigned W = 24;

    logic         start;
    logic [W-1:0] len;
    logic [7:0]   byte_in;
    logic         byte_valid;
    logic         byte_ready;
    logic [W-1:0] waddr;
    logic [W-1:0] wdata;
    logic         wen;
    logic         proc_rst;
    logic         done;
    logic         err;

    // Host side: requests loads and supplies bytes
    modport master (
        output start, len, byte_in, byte_valid,
        input  byte_ready, waddr, wdata, wen, proc_rst, done, err
    );

    // Loader side
    modport slave (
        input  start, len, byte_in, byte_valid,
        output byte_ready, waddr, wdata, wen, proc_rst, done, err
    );
endinterface

// File: rtl/boot_loader.sv
// Boot loader: packs host bytes little-endian into 24-bit words, writes them to
// memory, then releases the processor from reset.
module boot_loader #(
    parameter int unsigned MEM_SIZE = 128
) (
    input  logic          clk,
    input  logic          rst,
    boot_loader_if.slave  bus
);
    localparam int unsigned W  = 24;
    localparam int unsigned CW = W + 1;

    typedef enum logic [2:0] {IDLE, B0, B1, B2, WRITE, RUN, ERR} state_t;

    state_t         state;
    state_t         next_state;
    logic [W-1:0]   len_q;
    logic [W-1:0]   cnt_q;
    logic [15:0]    asm_q;

    logic           byte_ready_q;
    logic           wen_q;
    logic [W-1:0]   waddr_q;
    logic [W-1:0]   wdata_q;
    logic           proc_rst_q;
    logic           done_q;
    logic           err_q;

    logic           byte_ready_d;
    logic           wen_d;
    logic           proc_rst_d;
    logic           done_d;
    logic           err_d;

    logic           accept;
    logic           start_ok;
    logic           more_words;

    // byte_ready_q is high exactly in B0..B2, so it doubles as the accept qualifier
    assign accept     = byte_ready_q & bus.byte_valid;
    assign start_ok   = bus.start & ((state == IDLE) | (state == RUN) | (state == ERR));
    assign more_words = (CW'(cnt_q) + CW'(1)) < CW'(len_q);

    assign bus.byte_ready = byte_ready_q;
    assign bus.wen        = wen_q;
    assign bus.waddr      = waddr_q;
    assign bus.wdata      = wdata_q;
    assign bus.proc_rst   = proc_rst_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; start only honoured when no load is in flight
    always_comb begin
        next_state = state;
        if (start_ok) begin
            if (bus.len == '0) begin
                next_state = RUN;
            end else if (bus.len > W'(MEM_SIZE)) begin
                next_state = ERR;
            end else begin
                next_state = B0;
            end
        end else begin
            case (state)
                B0:      if (accept) next_state = B1;
                B1:      if (accept) next_state = B2;
                B2:      if (accept) next_state = WRITE;
                WRITE:   next_state = more_words ? B0 : RUN;
                default: next_state = state;
            endcase
        end
    end

    // Output decode from the upcoming state, so registered outputs line up with it
    always_comb begin
        byte_ready_d = 1'b0;
        wen_d        = 1'b0;
        proc_rst_d   = 1'b1;
        done_d       = 1'b0;
        err_d        = 1'b0;
        case (next_state)
            B0, B1, B2: byte_ready_d = 1'b1;
            WRITE:      wen_d        = 1'b1;
            RUN: begin
                proc_rst_d = 1'b0;
                done_d     = 1'b1;
            end
            ERR:        err_d        = 1'b1;
            default:    ;
        endcase
    end

    // Output registers and datapath: length latch, word counter, byte assembly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_ready_q <= 1'b0;
            wen_q        <= 1'b0;
            waddr_q      <= '0;
            wdata_q      <= '0;
            proc_rst_q   <= 1'b1;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            len_q        <= '0;
            cnt_q        <= '0;
            asm_q        <= '0;
        end else begin
            byte_ready_q <= byte_ready_d;
            wen_q        <= wen_d;
            proc_rst_q   <= proc_rst_d;
            done_q       <= done_d;
            err_q        <= err_d;
            if (start_ok) begin
                len_q <= bus.len;
                cnt_q <= '0;
            end else if (state == WRITE) begin
                cnt_q <= cnt_q + W'(1);
            end
            if (accept) begin
                case (state)
                    B0:      asm_q[7:0]  <= bus.byte_in;
                    B1:      asm_q[15:8] <= bus.byte_in;
                    B2: begin
                        wdata_q <= {bus.byte_in, asm_q};
                        waddr_q <= cnt_q;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader with a write log sampled on the falling edge.
module tb_boot_loader;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    logic [23:0] log_addr[$];
    logic [23:0] log_data[$];

    boot_loader_if bus();

    boot_loader #(.MEM_SIZE(128)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every memory write away from the active edge
    always @(negedge clk) begin
        if (bus.wen === 1'b1) begin
            log_addr.push_back(bus.waddr);
            log_data.push_back(bus.wdata);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [23:0] l);
        bus.start = 1'b1;
        bus.len   = l;
        step();
        bus.start = 1'b0;
    endtask

    // Offer a byte and hold it until an edge where byte_ready was high
    task automatic push_byte(input logic [7:0] b);
        logic rb;
        bit   ok;
        ok = 0;
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rb = bus.byte_ready;
            step();
            if (rb) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    initial begin
        logic [7:0]  t2b[3];
        logic [7:0]  b0, b1, b2;
        logic        v, rb;
        int          idx;

        checks   = 0;
        failures = 0;
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.len        = '0;
        bus.byte_in    = '0;
        bus.byte_valid = 1'b0;

        // Reset values
        #2;
        check("rst_ready",    32'(bus.byte_ready), 32'd0);
        check("rst_wen",      32'(bus.wen),        32'd0);
        check("rst_waddr",    32'(bus.waddr),      32'd0);
        check("rst_wdata",    32'(bus.wdata),      32'd0);
        check("rst_proc_rst", 32'(bus.proc_rst),   32'd1);
        check("rst_done",     32'(bus.done),       32'd0);
        check("rst_err",      32'(bus.err),        32'd0);
        step();
        step();
        rst = 1'b0;
        step();
        check("idle_hold", 32'(bus.byte_ready), 32'd0);

        // len=2, six bytes back-to-back
        clear_log();
        do_start(24'd2);
        check("t1_ready_b0", 32'(bus.byte_ready), 32'd1);
        check("t1_proc_rst", 32'(bus.proc_rst),   32'd1);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        check("t1_wen0",   32'(bus.wen),        32'd1);
        check("t1_waddr0", 32'(bus.waddr),      32'd0);
        check("t1_wdata0", 32'(bus.wdata),      32'h332211);
        check("t1_rdy_wr", 32'(bus.byte_ready), 32'd0);
        push_byte(8'h44);
        check("t1_hold_addr", 32'(bus.waddr), 32'd0);
        check("t1_hold_data", 32'(bus.wdata), 32'h332211);
        check("t1_wen_off",   32'(bus.wen),   32'd0);
        push_byte(8'h55);
        push_byte(8'h66);
        bus.byte_valid = 1'b0;
        check("t1_wen1",   32'(bus.wen),   32'd1);
        check("t1_waddr1", 32'(bus.waddr), 32'd1);
        check("t1_wdata1", 32'(bus.wdata), 32'h665544);
        step();
        check("t1_done",     32'(bus.done),     32'd1);
        check("t1_proc_rel", 32'(bus.proc_rst), 32'd0);
        check("t1_nwrites",  32'(log_addr.size()), 32'd2);

        // len=1 with byte_valid toggling each cycle
        clear_log();
        t2b = '{8'hAA, 8'hBB, 8'hCC};
        do_start(24'd1);
        idx = 0;
        for (int c = 0; c < 30 && idx < 3; c++) begin
            v = (c % 2 == 0);
            bus.byte_valid = v;
            bus.byte_in    = t2b[idx];
            rb = bus.byte_ready;
            check("t2_ready", 32'(rb), 32'd1);
            step();
            if (v && rb) idx++;
        end
        bus.byte_valid = 1'b0;
        check("t2_bytes",  32'(idx),            32'd3);
        check("t2_wen",    32'(bus.wen),        32'd1);
        check("t2_wdata",  32'(bus.wdata),      32'hCCBBAA);
        check("t2_waddr",  32'(bus.waddr),      32'd0);
        check("t2_rdy_wr", 32'(bus.byte_ready), 32'd0);
        step();
        check("t2_done",   32'(bus.done),       32'd1);
        check("t2_rdy_rn", 32'(bus.byte_ready), 32'd0);
        check("t2_nwrites", 32'(log_addr.size()), 32'd1);

        // len=129 is rejected
        clear_log();
        do_start(24'd129);
        check("t3_err",      32'(bus.err),        32'd1);
        check("t3_proc_rst", 32'(bus.proc_rst),   32'd1);
        check("t3_ready",    32'(bus.byte_ready), 32'd0);
        check("t3_done",     32'(bus.done),       32'd0);
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'h77;
        repeat (4) step();
        bus.byte_valid = 1'b0;
        check("t3_err_hold", 32'(bus.err),        32'd1);
        check("t3_nwrites",  32'(log_addr.size()), 32'd0);

        // len=0 goes straight to RUN
        do_start(24'd0);
        check("t3z_done",     32'(bus.done),     32'd1);
        check("t3z_err",      32'(bus.err),      32'd0);
        check("t3z_proc_rst", 32'(bus.proc_rst), 32'd0);
        check("t3z_wen",      32'(bus.wen),      32'd0);
        step();
        check("t3z_nwrites",  32'(log_addr.size()), 32'd0);

        // len=MEM_SIZE fills the whole memory
        clear_log();
        do_start(24'd128);
        for (int i = 0; i < 128; i++) begin
            push_byte(8'(i));
            push_byte(8'(i) ^ 8'h5A);
            push_byte(~8'(i));
        end
        bus.byte_valid = 1'b0;
        check("t4_last_addr", 32'(bus.waddr), 32'd127);
        check("t4_last_wen",  32'(bus.wen),   32'd1);
        step();
        check("t4_done",     32'(bus.done),        32'd1);
        check("t4_nwrites",  32'(log_addr.size()), 32'd128);
        for (int i = 0; i < 128 && i < log_addr.size(); i++) begin
            b0 = 8'(i);
            b1 = 8'(i) ^ 8'h5A;
            b2 = ~8'(i);
            check("t4_addr", 32'(log_addr[i]), 32'(i));
            check("t4_data", 32'(log_data[i]), 32'({b2, b1, b0}));
        end

        // Reset in the middle of word 0
        clear_log();
        do_start(24'd1);
        push_byte(8'h12);
        push_byte(8'h34);
        rst = 1'b1;
        bus.byte_valid = 1'b0;
        #2;
        check("t5_ready",    32'(bus.byte_ready), 32'd0);
        check("t5_wen",      32'(bus.wen),        32'd0);
        check("t5_waddr",    32'(bus.waddr),      32'd0);
        check("t5_wdata",    32'(bus.wdata),      32'd0);
        check("t5_proc_rst", 32'(bus.proc_rst),   32'd1);
        check("t5_done",     32'(bus.done),       32'd0);
        step();
        rst = 1'b0;
        step();
        step();
        check("t5_idle", 32'(bus.byte_ready), 32'd0);
        do_start(24'd1);
        push_byte(8'h9A);
        push_byte(8'hBC);
        push_byte(8'hDE);
        bus.byte_valid = 1'b0;
        check("t5_wdata_new", 32'(bus.wdata), 32'hDEBC9A);
        check("t5_waddr_new", 32'(bus.waddr), 32'd0);
        step();
        check("t5_nwrites", 32'(log_addr.size()), 32'd1);
        check("t5_done_new", 32'(bus.done), 32'd1);

        // start during B1 is ignored; start in RUN reloads
        clear_log();
        do_start(24'd2);
        push_byte(8'h01);
        bus.byte_valid = 1'b0;
        do_start(24'd5);
        check("t6_ign_ready", 32'(bus.byte_ready), 32'd1);
        check("t6_ign_prst",  32'(bus.proc_rst),   32'd1);
        push_byte(8'h02);
        push_byte(8'h03);
        check("t6_wdata0", 32'(bus.wdata), 32'h030201);
        check("t6_waddr0", 32'(bus.waddr), 32'd0);
        push_byte(8'h04);
        push_byte(8'h05);
        push_byte(8'h06);
        bus.byte_valid = 1'b0;
        check("t6_wdata1", 32'(bus.wdata), 32'h060504);
        step();
        check("t6_done", 32'(bus.done), 32'd1);
        do_start(24'd1);
        check("t6_re_prst",  32'(bus.proc_rst),   32'd1);
        check("t6_re_done",  32'(bus.done),       32'd0);
        check("t6_re_ready", 32'(bus.byte_ready), 32'd1);
        push_byte(8'h07);
        push_byte(8'h08);
        push_byte(8'h09);
        bus.byte_valid = 1'b0;
        check("t6_re_wdata", 32'(bus.wdata), 32'h090807);
        check("t6_re_waddr", 32'(bus.waddr), 32'd0);
        step();
        check("t6_nwrites", 32'(log_addr.size()), 32'd3);
        check("t6_re_done2", 32'(bus.done), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
